// File: rtl/gray_stream_pkg.sv
// Shared definitions for the gray-ramp test-pattern stream.
// Holds geometry defaults, checker state encoding and the expected-data rule.
package gray_stream_pkg;

    // Default geometry: 1280 pixels / 4 per beat, 1024 lines.
    localparam int L_NUM_DEF = 320;
    localparam int V_NUM_DEF = 1024;

    // Checker state encoding.
    localparam logic [0:0] ST_SYNC  = 1'b0;
    localparam logic [0:0] ST_FRAME = 1'b1;

    // Every pixel of a line carries the gray level row[9:2].
    function automatic logic [31:0] exp_data(input logic [15:0] row);
        logic [7:0] lvl;
        lvl = 8'(row >> 2);
        return {4{lvl}};
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sat_cnt16.sv
// Saturating 16-bit event counter.
// Ports: clk, rst (async, active-high), inc (count enable), cnt (value).
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 16'd0;
        end else if (inc && cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/gray_scale_check.sv
// Sink/checker for the gray-ramp stream: verifies line length, frame height,
// framing flags and payload; reports per-frame result and error statistics.
// Ports: data_clk, rst (async, active-high), tvalid/tdata/h_last/v_last in;
// frame_done, frame_ok, frame_cnt, line_err_cnt, data_err_cnt, frame_err_cnt out.
module gray_scale_check
    import gray_stream_pkg::*;
#(
    parameter int L_NUM      = L_NUM_DEF,
    parameter int V_NUM      = V_NUM_DEF,
    parameter bit CHECK_DATA = 1'b1
) (
    input  logic        data_clk,
    input  logic        rst,
    input  logic        tvalid,
    input  logic [31:0] tdata,
    input  logic        h_last,
    input  logic        v_last,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] frame_cnt,
    output logic [15:0] line_err_cnt,
    output logic [15:0] data_err_cnt,
    output logic [15:0] frame_err_cnt
);

    localparam logic [15:0] COL_LAST = 16'(L_NUM - 1);
    localparam logic [15:0] ROW_LAST = 16'(V_NUM - 1);

    logic [0:0]  state;
    logic [15:0] col;
    logic [15:0] row;
    logic        ferr;
    // Set when a line at or past the last row ended without v_last.
    logic        ovr;

    logic beat;
    logic eof;
    logic data_inc;
    logic line_inc;
    logic frame_inc;

    always_comb begin
        beat      = (state == ST_FRAME) && tvalid;
        eof       = beat && v_last;
        data_inc  = beat && CHECK_DATA && (tdata != exp_data(row));
        line_inc  = beat && h_last && (col != COL_LAST);
        frame_inc = eof && (!h_last || row != ROW_LAST || ovr);
    end

    always_ff @(posedge data_clk or posedge rst) begin
        if (rst) begin
            state      <= ST_SYNC;
            col        <= 16'd0;
            row        <= 16'd0;
            ferr       <= 1'b0;
            ovr        <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
        end else begin
            frame_done <= eof;
            if (state == ST_SYNC) begin
                // Discard everything until a frame boundary is seen.
                if (tvalid && v_last) begin
                    state <= ST_FRAME;
                    col   <= 16'd0;
                    row   <= 16'd0;
                    ferr  <= 1'b0;
                    ovr   <= 1'b0;
                end
            end else if (tvalid) begin
                if (v_last) begin
                    // Errors found on this closing beat count too.
                    frame_ok <= !(ferr | data_inc | line_inc | frame_inc);
                    col      <= 16'd0;
                    row      <= 16'd0;
                    ferr     <= 1'b0;
                    ovr      <= 1'b0;
                end else begin
                    if (data_inc || line_inc) begin
                        ferr <= 1'b1;
                    end
                    if (h_last) begin
                        col <= 16'd0;
                        row <= sat_inc(row);
                        if (row >= ROW_LAST) begin
                            ovr <= 1'b1;
                        end
                    end else begin
                        col <= sat_inc(col);
                    end
                end
            end
        end
    end

    sat_cnt16 u_frame_cnt (
        .clk (data_clk),
        .rst (rst),
        .inc (eof),
        .cnt (frame_cnt)
    );

    sat_cnt16 u_line_err_cnt (
        .clk (data_clk),
        .rst (rst),
        .inc (line_inc),
        .cnt (line_err_cnt)
    );

    sat_cnt16 u_data_err_cnt (
        .clk (data_clk),
        .rst (rst),
        .inc (data_inc),
        .cnt (data_err_cnt)
    );

    sat_cnt16 u_frame_err_cnt (
        .clk (data_clk),
        .rst (rst),
        .inc (frame_inc),
        .cnt (frame_err_cnt)
    );

endmodule

// File: tb/tb_gray_scale_check.sv
// Randomized self-checking bench for gray_scale_check, reduced geometry.
// Frames are described as line-length lists plus corruptions; a frame-level model predicts results.
module tb_gray_scale_check;

    localparam int L = 16;
    localparam int V = 32;

    logic        data_clk = 1'b0;
    logic        rst      = 1'b1;
    logic        tvalid   = 1'b0;
    logic [31:0] tdata    = '0;
    logic        h_last   = 1'b0;
    logic        v_last   = 1'b0;
    logic        frame_done;
    logic        frame_ok;
    logic [15:0] frame_cnt;
    logic [15:0] line_err_cnt;
    logic [15:0] data_err_cnt;
    logic [15:0] frame_err_cnt;

    gray_scale_check #(
        .L_NUM      (L),
        .V_NUM      (V),
        .CHECK_DATA (1'b1)
    ) dut (
        .data_clk      (data_clk),
        .rst           (rst),
        .tvalid        (tvalid),
        .tdata         (tdata),
        .h_last        (h_last),
        .v_last        (v_last),
        .frame_done    (frame_done),
        .frame_ok      (frame_ok),
        .frame_cnt     (frame_cnt),
        .line_err_cnt  (line_err_cnt),
        .data_err_cnt  (data_err_cnt),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 data_clk = ~data_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;

    always @(negedge data_clk) begin
        if (frame_done) pulses++;
    end

    // Frame description
    int          lens[$];
    bit          final_h;
    int          cr[$];
    int          cb[$];
    logic [31:0] cd[$];

    // Reference model state
    int m_frames = 0;
    int m_line   = 0;
    int m_data   = 0;
    int m_ferr   = 0;
    int m_pulses = 0;
    bit m_ok     = 1'b0;

    function automatic logic [31:0] ramp(input int r);
        logic [7:0] b;
        b = 8'((r / 4) % 256);
        return {b, b, b, b};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input bit v, input logic [31:0] d,
                       input bit h, input bit vl);
        @(posedge data_clk);
        #1;
        tvalid = v;
        tdata  = d;
        h_last = h;
        v_last = vl;
    endtask

    task automatic clean_cfg(input int n);
        lens.delete();
        cr.delete();
        cb.delete();
        cd.delete();
        final_h = 1'b1;
        for (int i = 0; i < n; i++) lens.push_back(L);
    endtask

    task automatic add_corrupt(input int r, input int b, input logic [31:0] d);
        for (int k = 0; k < cr.size(); k++) begin
            if (cr[k] == r && cb[k] == b) return;
        end
        cr.push_back(r);
        cb.push_back(b);
        cd.push_back((d == ramp(r)) ? ~d : d);
    endtask

    task automatic send_lines(input int r0, input bit with_v, input bit gaps);
        int n;
        n = lens.size();
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < lens[i]; b++) begin
                bit          last;
                bit          eol;
                logic [31:0] d;
                last = with_v && (i == n - 1) && (b == lens[i] - 1);
                eol  = (b == lens[i] - 1) && (!last || final_h);
                d    = ramp(r0 + i);
                for (int k = 0; k < cr.size(); k++) begin
                    if (cr[k] == i && cb[k] == b) d = cd[k];
                end
                if (gaps) begin
                    int g;
                    g = $urandom_range(0, 5);
                    for (int j = 0; j < g; j++) begin
                        put(1'b0, $urandom, 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)));
                    end
                end
                put(1'b1, d, eol, last);
            end
        end
        put(1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    // Frame-level prediction straight from the checking rules.
    task automatic model_frame();
        int n;
        bit fe;
        bit le;
        n  = lens.size();
        le = 1'b0;
        for (int i = 0; i < n; i++) begin
            if ((i < n - 1 || final_h) && lens[i] != L) begin
                m_line++;
                le = 1'b1;
            end
        end
        m_data += cr.size();
        fe = !final_h || (n != V);
        if (fe) m_ferr++;
        m_frames++;
        m_pulses++;
        m_ok = !le && (cr.size() == 0) && !fe;
    endtask

    task automatic check_frame(input string tag);
        repeat (2) @(negedge data_clk);
        chk({tag, ".ok"}, 32'(frame_ok), 32'(m_ok));
        chk({tag, ".frames"}, 32'(frame_cnt), 32'(m_frames));
        chk({tag, ".line_err"}, 32'(line_err_cnt), 32'(m_line));
        chk({tag, ".data_err"}, 32'(data_err_cnt), 32'(m_data));
        chk({tag, ".frame_err"}, 32'(frame_err_cnt), 32'(m_ferr));
        chk({tag, ".pulses"}, 32'(pulses), 32'(m_pulses));
        chk({tag, ".done_low"}, 32'(frame_done), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".done"}, 32'(frame_done), 32'd0);
        chk({tag, ".ok"}, 32'(frame_ok), 32'd0);
        chk({tag, ".frames"}, 32'(frame_cnt), 32'd0);
        chk({tag, ".line_err"}, 32'(line_err_cnt), 32'd0);
        chk({tag, ".data_err"}, 32'(data_err_cnt), 32'd0);
        chk({tag, ".frame_err"}, 32'(frame_err_cnt), 32'd0);
    endtask

    task automatic run_frame(input string tag, input bit gaps);
        model_frame();
        send_lines(0, 1'b1, gaps);
        check_frame(tag);
    endtask

    initial begin
        repeat (3) @(posedge data_clk);
        @(negedge data_clk);
        check_zero("reset");
        #1 rst = 1'b0;

        // Source joins mid-frame: tail of a frame is discarded.
        clean_cfg(3);
        send_lines(V - 3, 1'b1, 1'b0);
        repeat (2) @(negedge data_clk);
        chk("sync.pulses", 32'(pulses), 32'(m_pulses));
        check_zero("sync");

        clean_cfg(V);
        run_frame("clean1", 1'b0);

        clean_cfg(V);
        add_corrupt(5, 10, 32'hDEADBEEF);
        run_frame("corrupt", 1'b0);

        clean_cfg(V);
        run_frame("clean2", 1'b0);

        clean_cfg(V);
        lens[8] = L - 1;
        run_frame("short_line", 1'b0);

        clean_cfg(V / 2);
        run_frame("early_vlast", 1'b0);

        clean_cfg(V);
        run_frame("clean3", 1'b0);

        clean_cfg(V);
        run_frame("gaps", 1'b1);

        clean_cfg(V + 1);
        run_frame("overrun", 1'b0);

        clean_cfg(V);
        final_h = 1'b0;
        run_frame("no_hlast", 1'b0);

        for (int f = 0; f < 5; f++) begin
            int sel;
            int n;
            int nc;
            sel = $urandom_range(0, 3);
            n = (sel == 2) ? V - 1 : (sel == 3) ? V + 1 : V;
            clean_cfg(n);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    lens[i] = ($urandom_range(0, 1) == 1) ? L + 1 : L - 1;
                end
            end
            final_h = ($urandom_range(0, 7) != 0);
            nc = $urandom_range(0, 2);
            for (int k = 0; k < nc; k++) begin
                int r;
                r = $urandom_range(0, n - 1);
                add_corrupt(r, $urandom_range(0, lens[r] - 1), $urandom);
            end
            run_frame($sformatf("rand%0d", f), 1'b1);
        end

        // Reset mid-frame, then the frame tail must be ignored.
        clean_cfg(21);
        send_lines(0, 1'b0, 1'b0);
        @(posedge data_clk);
        #1 rst = 1'b1;
        @(negedge data_clk);
        check_zero("midrst");
        @(posedge data_clk);
        #1 rst = 1'b0;
        m_frames = 0;
        m_line   = 0;
        m_data   = 0;
        m_ferr   = 0;
        clean_cfg(V - 21);
        send_lines(21, 1'b1, 1'b0);
        repeat (2) @(negedge data_clk);
        chk("tail.pulses", 32'(pulses), 32'(m_pulses));
        chk("tail.frames", 32'(frame_cnt), 32'd0);

        clean_cfg(V);
        run_frame("after_rst", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
